// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
//   Vector memory stage that sits right after execute. On NONE it passes the
//   ALU vector through to writeback. LOAD and STORE move one element per cycle
//   through a single-port, element-wide data memory, and hold upstream frozen
//   with stall for the rest of the transfer.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   MemOp      00 NONE, 01 LOAD, 10 STORE, 11 treated as NONE (sampled in IDLE)
//   base_addr  element address of lane 0
//   vect_alu   execute-stage result vector (lane i = bits [i*W +: W])
//   vect_st    store-data vector (captured on the first store cycle)
//   mem_addr   data-memory address (combinational)
//   mem_wdata  data-memory write data (combinational)
//   mem_we     data-memory write enable (combinational)
//   mem_rdata  data-memory read data, valid one cycle after its address
//   stall      freeze request to upstream stages (combinational)
//   vect_out   registered result vector to writeback
//   out_valid  registered, high for the one cycle after vect_out is written
// -----------------------------------------------------------------------------
module stage_memory #(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [1:0]                         MemOp,
  input  logic [addrWidth-1:0]               base_addr,
  input  logic [vectorSize*registerSize-1:0] vect_alu,
  input  logic [vectorSize*registerSize-1:0] vect_st,
  output logic [addrWidth-1:0]               mem_addr,
  output logic [registerSize-1:0]            mem_wdata,
  output logic                               mem_we,
  input  logic [registerSize-1:0]            mem_rdata,
  output logic                               stall,
  output logic [vectorSize*registerSize-1:0] vect_out,
  output logic                               out_valid
);

  localparam int VW = vectorSize * registerSize;
  localparam int CW = $clog2(vectorSize + 1);
  // Counter value on the final LOAD cycle (all lanes fetched).
  localparam logic [CW-1:0] LD_LAST_C = CW'(vectorSize);
  // Counter value on the final STORE cycle (last lane written).
  localparam logic [CW-1:0] ST_LAST_C = CW'(vectorSize - 1);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [CW-1:0]          cnt_r, cnt_nx_s;
  logic [addrWidth-1:0]   base_r, base_nx_s;
  logic [VW-1:0]          st_r, st_nx_s;
  logic [VW-1:0]          ld_r, ld_nx_s;
  logic [VW-1:0]          vout_nx_s;
  logic                   ov_nx_s;

  logic [VW-1:0]          ld_cap_s;
  logic [registerSize-1:0] st_lane_s;

  logic [addrWidth-1:0]   addr_s;
  logic [registerSize-1:0] wdata_s;
  logic                   we_s;
  logic                   stall_s;

  // Load buffer with the lane addressed by the counter replaced by mem_rdata;
  // on the last LOAD cycle this is the complete vector, last lane included.
  always_comb begin
    ld_cap_s = ld_r;
    for (int i = 0; i < vectorSize; i++) begin
      ld_cap_s[i*registerSize +: registerSize] =
        (cnt_r == CW'(i + 1)) ? mem_rdata : ld_r[i*registerSize +: registerSize];
    end
  end

  // Select the latched store lane addressed by the counter (AND-OR mux).
  always_comb begin
    st_lane_s = '0;
    for (int i = 0; i < vectorSize; i++) begin
      st_lane_s = st_lane_s |
        ({registerSize{cnt_r == CW'(i)}} & st_r[i*registerSize +: registerSize]);
    end
  end

  // Next-state, datapath updates and ungated memory-side outputs.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    base_nx_s  = base_r;
    st_nx_s    = st_r;
    ld_nx_s    = ld_r;
    vout_nx_s  = vect_out;
    ov_nx_s    = 1'b0;
    addr_s     = '0;
    wdata_s    = '0;
    we_s       = 1'b0;
    stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        case (MemOp)
          OP_LOAD: begin
            addr_s     = base_addr;
            stall_s    = 1'b1;
            base_nx_s  = base_addr;
            cnt_nx_s   = CW'(1);
            state_nx_s = LOAD;
          end
          OP_STORE: begin
            addr_s    = base_addr;
            wdata_s   = vect_st[registerSize-1:0];
            we_s      = 1'b1;
            base_nx_s = base_addr;
            st_nx_s   = vect_st;
            // A single-lane store finishes in this cycle.
            if (LD_LAST_C > CW'(1)) begin
              stall_s    = 1'b1;
              cnt_nx_s   = CW'(1);
              state_nx_s = STORE;
            end else begin
              stall_s    = 1'b0;
              cnt_nx_s   = '0;
              state_nx_s = IDLE;
            end
          end
          default: begin
            vout_nx_s = vect_alu;
            ov_nx_s   = 1'b1;
          end
        endcase
      end
      LOAD: begin
        ld_nx_s = ld_cap_s;
        if (cnt_r < LD_LAST_C) begin
          addr_s   = base_r + addrWidth'(cnt_r);
          stall_s  = 1'b1;
          cnt_nx_s = cnt_r + CW'(1);
        end else begin
          // Whole vector published at once; partial lanes never reach vect_out.
          vout_nx_s  = ld_cap_s;
          ov_nx_s    = 1'b1;
          cnt_nx_s   = '0;
          state_nx_s = IDLE;
        end
      end
      STORE: begin
        addr_s  = base_r + addrWidth'(cnt_r);
        wdata_s = st_lane_s;
        we_s    = 1'b1;
        if (cnt_r < ST_LAST_C) begin
          stall_s  = 1'b1;
          cnt_nx_s = cnt_r + CW'(1);
        end else begin
          stall_s    = 1'b0;
          cnt_nx_s   = '0;
          state_nx_s = IDLE;
        end
      end
      default: begin
        cnt_nx_s   = '0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Force memory controls and stall quiet while reset is asserted, without
  // waiting for a clock edge.
  always_comb begin
    if (!reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      stall     = 1'b0;
    end else begin
      mem_addr  = addr_s;
      mem_wdata = wdata_s;
      mem_we    = we_s;
      stall     = stall_s;
    end
  end

  // State, counter, latched operands and registered writeback outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      base_r    <= '0;
      st_r      <= '0;
      ld_r      <= '0;
      vect_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      base_r    <= base_nx_s;
      st_r      <= st_nx_s;
      ld_r      <= ld_nx_s;
      vect_out  <= vout_nx_s;
      out_valid <= ov_nx_s;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// -----------------------------------------------------------------------------
// tb_stage_memory
//   Self-checking bench for stage_memory with a registered-read memory model.
//   Expected result vectors and memory writes are queued when stimulus is
//   driven and compared when the DUT raises out_valid / mem_we.
// -----------------------------------------------------------------------------
module tb_stage_memory;

  localparam int RS = 8;
  localparam int VS = 4;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        MemOp;
  logic [AW-1:0]     base_addr;
  logic [VS*RS-1:0]  vect_alu;
  logic [VS*RS-1:0]  vect_st;
  logic [AW-1:0]     mem_addr;
  logic [RS-1:0]     mem_wdata;
  logic              mem_we;
  logic [RS-1:0]     mem_rdata;
  logic              stall;
  logic [VS*RS-1:0]  vect_out;
  logic              out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_vq[$];
  logic [15:0] exp_wq[$];

  logic [7:0]   mem [256];
  logic [255:0] wr_flag;
  logic         tb_init;

  always #5 clk = ~clk;

  stage_memory #(
    .registerSize(RS),
    .vectorSize  (VS),
    .addrWidth   (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemOp    (MemOp),
    .base_addr(base_addr),
    .vect_alu (vect_alu),
    .vect_st  (vect_st),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .stall    (stall),
    .vect_out (vect_out),
    .out_valid(out_valid)
  );

  // Unwritten locations hold a fixed pattern: 0x10..0x13 -> A0..A3.
  function automatic logic [7:0] init_val(logic [7:0] a);
    return {a[7:4] ^ 4'hB, a[3:0]};
  endfunction

  function automatic logic [7:0] rd(logic [7:0] a);
    return wr_flag[a] ? mem[a] : init_val(a);
  endfunction

  // Data memory: synchronous write, read data registered one cycle.
  always @(posedge clk) begin
    if (tb_init) begin
      wr_flag <= '0;
    end else if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
    end
    mem_rdata <= rd(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: called at the falling edge each cycle.
  task automatic sample();
    logic [15:0] w;
    if (out_valid) begin
      if (exp_vq.size() > 0) check("vect_out", vect_out, exp_vq.pop_front());
      else                   check("out_valid_spurious", 32'(out_valid), 32'd0);
    end
    if (mem_we) begin
      if (exp_wq.size() > 0) begin
        w = exp_wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w[15:8]));
        check("wr_data", 32'(mem_wdata), 32'(w[7:0]));
      end else begin
        check("mem_we_spurious", 32'(mem_we), 32'd0);
      end
    end
  endtask

  task automatic cycle_end();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_hold();
    cycle_end();
    cycle_end();
    MemOp = 2'b00;
    reset = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    MemOp     = 2'b10;
    base_addr = 8'h55;
    vect_st   = 32'hDEADBEEF;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_vout", vect_out, 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    rst_hold();
  endtask

  task automatic do_none(input logic [31:0] alu);
    MemOp    = 2'b00;
    vect_alu = alu;
    exp_vq.push_back(alu);
    #2;
    check("none_stall", 32'(stall), 32'd0);
    check("none_we", 32'(mem_we), 32'd0);
    check("none_addr", 32'(mem_addr), 32'd0);
    cycle_end();
  endtask

  task automatic do_load(input logic [7:0] base, input int abort_at);
    logic [31:0] e;
    for (int i = 0; i < VS; i++) e[i*RS +: RS] = rd(8'(base + 8'(i)));
    MemOp     = 2'b01;
    base_addr = base;
    if (abort_at < 0) exp_vq.push_back(e);
    #2;
    check("ld_addr0", 32'(mem_addr), 32'(base));
    check("ld_stall0", 32'(stall), 32'd1);
    cycle_end();
    // Upstream is frozen: these must all be ignored.
    MemOp     = 2'b10;
    vect_st   = 32'hBADC0FFE;
    base_addr = ~base;
    for (int k = 1; k <= VS; k++) begin
      #2;
      if (k < VS) begin
        check("ld_addr", 32'(mem_addr), 32'(8'(base + 8'(k))));
        check("ld_stall", 32'(stall), 32'd1);
      end else begin
        check("ld_addr_last", 32'(mem_addr), 32'd0);
        check("ld_stall_last", 32'(stall), 32'd0);
      end
      check("ld_we", 32'(mem_we), 32'd0);
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check("ldab_addr", 32'(mem_addr), 32'd0);
        check("ldab_stall", 32'(stall), 32'd0);
        check("ldab_vout", vect_out, 32'd0);
        check("ldab_ov", 32'(out_valid), 32'd0);
        rst_hold();
        return;
      end
      cycle_end();
    end
  endtask

  task automatic do_store(input logic [7:0] base, input logic [31:0] st, input int abort_at);
    logic [31:0] prev;
    int nw;
    prev = vect_out;
    nw = (abort_at < 0) ? VS : abort_at;
    for (int i = 0; i < nw; i++) exp_wq.push_back({8'(base + 8'(i)), st[i*RS +: RS]});
    MemOp     = 2'b10;
    base_addr = base;
    vect_st   = st;
    #2;
    check("st_addr0", 32'(mem_addr), 32'(base));
    check("st_we0", 32'(mem_we), 32'd1);
    check("st_stall0", 32'(stall), 32'd1);
    cycle_end();
    // Changes after cycle 0 must not affect the store.
    vect_st   = ~st;
    MemOp     = 2'b01;
    base_addr = ~base;
    for (int k = 1; k < VS; k++) begin
      #2;
      check("st_addr", 32'(mem_addr), 32'(8'(base + 8'(k))));
      check("st_we", 32'(mem_we), 32'd1);
      check("st_stall", 32'(stall), 32'(k < VS - 1));
      check("st_vout_hold", vect_out, prev);
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check("stab_we", 32'(mem_we), 32'd0);
        check("stab_stall", 32'(stall), 32'd0);
        check("stab_addr", 32'(mem_addr), 32'd0);
        rst_hold();
        return;
      end
      cycle_end();
    end
    check("st_vout_end", vect_out, prev);
  endtask

  initial begin
    tb_init   = 1'b1;
    MemOp     = 2'b00;
    base_addr = '0;
    vect_alu  = '0;
    vect_st   = '0;
    do_reset();
    tb_init = 1'b0;

    do_none(32'h04030201);
    do_none(32'hA5A55A5A);

    do_load(8'h10, -1);
    check("ld_vout_direct", vect_out, 32'hA3A2A1A0);
    check("ld_ov_direct", 32'(out_valid), 32'd1);

    do_store(8'hFE, 32'h44332211, -1);
    check("mem_FE", 32'(rd(8'hFE)), 32'h11);
    check("mem_FF", 32'(rd(8'hFF)), 32'h22);
    check("mem_00", 32'(rd(8'h00)), 32'h33);
    check("mem_01", 32'(rd(8'h01)), 32'h44);

    // Back-to-back LOAD then STORE.
    do_load(8'h20, -1);
    do_store(8'h30, 32'h88776655, -1);
    do_none(32'h11223344);

    // Reset during LOAD cycle 2, then normal pass-through.
    do_load(8'h40, 2);
    do_none(32'hCAFEF00D);

    // Reset during STORE cycle 2: only base and base+1 written.
    do_store(8'h50, 32'hDDCCBBAA, 2);
    check("stab_mem50", 32'(rd(8'h50)), 32'hAA);
    check("stab_mem51", 32'(rd(8'h51)), 32'hBB);
    check("stab_mem52", 32'(rd(8'h52)), 32'(init_val(8'h52)));

    // Load across the wrap point, reading the earlier store back.
    do_load(8'hFE, -1);
    check("wrap_ld_vout", vect_out, 32'h44332211);
    do_none(32'h00000000);
    cycle_end();

    check("vq_empty", 32'(exp_vq.size()), 32'd0);
    check("wq_empty", 32'(exp_wq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
